// File: rtl/gpio_port.sv
// gpio_port -- memory-mapped GPIO peripheral for the 6502 system bus.
//
// Up to 8 bidirectional pins with per-pin direction, an output toggle
// register, synchronised input readback and per-pin rising/falling edge
// detection feeding a sticky status register and a maskable IRQ.
//
// Ports:
//   clk      system clock, all state updates on the rising edge
//   reset    asynchronous, active-high reset
//   AB       register select (bus address bits [2:0])
//   DI       write data from the CPU
//   DO       registered read data, 8'h00 whenever no read was sampled
//   CS, WE   chip select and write enable
//   pin_in   raw asynchronous pad inputs
//   pin_out  DATA_OUT register
//   pin_oe   DIR register, 1 = drive the pin
//   irq      |(IRQ_STATUS & IRQ_EN)
//
// Register map: 0 DATA_OUT, 1 DIR, 2 PIN_IN (RO), 3 IRQ_EN, 4 EDGE_RISE,
// 5 EDGE_FALL, 6 IRQ_STATUS (write 1 to clear), 7 TOGGLE (WO, reads 0).
module gpio_port #(
  parameter int         WIDTH       = 8,
  parameter logic [7:0] RESET_OUT   = 8'h00,
  parameter int         SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       AB,
  input  logic [7:0]       DI,
  output logic [7:0]       DO,
  input  logic             CS,
  input  logic             WE,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] pin_out,
  output logic [WIDTH-1:0] pin_oe,
  output logic             irq
);

  localparam logic [WIDTH-1:0] RESET_VAL = RESET_OUT[WIDTH-1:0];

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_DIR    = 3'd1;
  localparam logic [2:0] A_PIN    = 3'd2;
  localparam logic [2:0] A_IRQEN  = 3'd3;
  localparam logic [2:0] A_RISE   = 3'd4;
  localparam logic [2:0] A_FALL   = 3'd5;
  localparam logic [2:0] A_STATUS = 3'd6;
  localparam logic [2:0] A_TOGGLE = 3'd7;

  // Zero-extend a WIDTH-bit register onto the 8-bit data bus.
  function automatic logic [7:0] zext(input logic [WIDTH-1:0] v);
    logic [7:0] r;
    r = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] irq_en_q, irq_en_d;
  logic [WIDTH-1:0] edge_rise_q, edge_rise_d;
  logic [WIDTH-1:0] edge_fall_q, edge_fall_d;
  logic [WIDTH-1:0] status_q, status_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [7:0]       do_q, do_d;

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] evt;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] w1c;
  logic             wr;
  logic             rd;
  logic [7:0]       rdata;

  assign s     = sync_q[SYNC_STAGES-1];
  assign wdata = DI[WIDTH-1:0];
  assign wr    = CS & WE;
  assign rd    = CS & ~WE;

  // Edge events run on every pin regardless of direction, so output pins
  // are observed through the pad loopback.
  assign evt = (s & ~prev_q & edge_rise_q) | (~s & prev_q & edge_fall_q);

  always_comb begin
    data_out_d  = data_out_q;
    dir_d       = dir_q;
    irq_en_d    = irq_en_q;
    edge_rise_d = edge_rise_q;
    edge_fall_d = edge_fall_q;
    w1c         = '0;
    if (wr) begin
      case (AB)
        A_DATA:   data_out_d  = wdata;
        A_DIR:    dir_d       = wdata;
        A_IRQEN:  irq_en_d    = wdata;
        A_RISE:   edge_rise_d = wdata;
        A_FALL:   edge_fall_d = wdata;
        A_STATUS: w1c         = wdata;
        A_TOGGLE: data_out_d  = data_out_q ^ wdata;
        default:  ;
      endcase
    end

    // A new event in the clearing cycle keeps its bit set.
    status_d = (status_q & ~w1c) | evt;

    sync_d = {sync_q[SYNC_STAGES-2:0], pin_in};
    prev_d = s;

    rdata = 8'h00;
    case (AB)
      A_DATA:   rdata = zext(data_out_q);
      A_DIR:    rdata = zext(dir_q);
      A_PIN:    rdata = zext(s);
      A_IRQEN:  rdata = zext(irq_en_q);
      A_RISE:   rdata = zext(edge_rise_q);
      A_FALL:   rdata = zext(edge_fall_q);
      A_STATUS: rdata = zext(status_q);
      default:  rdata = 8'h00;
    endcase
    // Idle cycles drive zero so the top can OR all slave DO buses.
    do_d = rd ? rdata : 8'h00;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out_q  <= RESET_VAL;
      dir_q       <= '0;
      irq_en_q    <= '0;
      edge_rise_q <= '0;
      edge_fall_q <= '0;
      status_q    <= '0;
      prev_q      <= '0;
      sync_q      <= '0;
      do_q        <= 8'h00;
    end else begin
      data_out_q  <= data_out_d;
      dir_q       <= dir_d;
      irq_en_q    <= irq_en_d;
      edge_rise_q <= edge_rise_d;
      edge_fall_q <= edge_fall_d;
      status_q    <= status_d;
      prev_q      <= prev_d;
      sync_q      <= sync_d;
      do_q        <= do_d;
    end
  end

  assign DO      = do_q;
  assign pin_out = data_out_q;
  assign pin_oe  = dir_q;
  assign irq     = |(status_q & irq_en_q);

endmodule

// File: tb/tb_gpio_port.sv
module tb_gpio_port;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] AB = '0;
  logic [7:0] DI = '0;
  logic       CS = 1'b0;
  logic       cs3 = 1'b0;
  logic       WE = 1'b0;

  logic [7:0] DO, do3;
  logic [7:0] pin_in = '0;
  logic [7:0] pin_out, pin_oe;
  logic       irq;
  logic [2:0] pin_in3 = '0;
  logic [2:0] pin_out3, pin_oe3;
  logic       irq3;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      tag;
    logic [7:0] exp;
    bit         sel3;
  } rd_exp_t;

  rd_exp_t sb_q[$];

  always #5 clk = ~clk;

  gpio_port #(.WIDTH(8), .RESET_OUT(8'hA5), .SYNC_STAGES(2)) u_dut (
    .clk(clk), .reset(reset), .AB(AB), .DI(DI), .DO(DO), .CS(CS), .WE(WE),
    .pin_in(pin_in), .pin_out(pin_out), .pin_oe(pin_oe), .irq(irq)
  );

  gpio_port #(.WIDTH(3), .RESET_OUT(8'hA5), .SYNC_STAGES(2)) u_dut3 (
    .clk(clk), .reset(reset), .AB(AB), .DI(DI), .DO(do3), .CS(cs3), .WE(WE),
    .pin_in(pin_in3), .pin_out(pin_out3), .pin_oe(pin_oe3), .irq(irq3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Read monitor: whenever a read is sampled, the DO of the next cycle
  // is compared against the oldest expectation in the scoreboard.
  always @(posedge clk) begin
    logic rd8, rd3;
    rd_exp_t e;
    rd8 = CS & ~WE & ~reset;
    rd3 = cs3 & ~WE & ~reset;
    #1;
    if (rd8 || rd3) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        check(e.tag, e.sel3 ? do3 : DO, e.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d, input bit sel3 = 0);
    AB = a; DI = d; WE = 1'b1;
    if (sel3) cs3 = 1'b1; else CS = 1'b1;
    tick();
    CS = 1'b0; cs3 = 1'b0; WE = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [7:0] exp, input string tag,
                          input bit sel3 = 0);
    rd_exp_t e;
    e.tag = tag; e.exp = exp; e.sel3 = sel3;
    sb_q.push_back(e);
    AB = a; WE = 1'b0;
    if (sel3) cs3 = 1'b1; else CS = 1'b1;
    tick();
    CS = 1'b0; cs3 = 1'b0;
  endtask

  initial begin
    // Reset values and reset asserted in the middle of a DIR write.
    ticks(2);
    check("rst_pin_out", pin_out, 8'hA5);
    check("rst_pin_oe", pin_oe, 8'h00);
    check("rst_irq", irq, 1'b0);
    check("rst_do", DO, 8'h00);
    check("rst_pin_out3", pin_out3, 3'h5);
    @(negedge clk);
    reset = 1'b0;
    tick();
    bus_write(3'd0, 8'h11);
    check("wr_data_pre", pin_out, 8'h11);
    @(negedge clk);
    AB = 3'd1; DI = 8'hFF; WE = 1'b1; CS = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("midrst_pin_out", pin_out, 8'hA5);
    tick();
    check("midrst_pin_oe", pin_oe, 8'h00);
    check("midrst_irq", irq, 1'b0);
    check("midrst_do", DO, 8'h00);
    CS = 1'b0; WE = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tick();
    bus_read(3'd1, 8'h00, "rd_dir_after_rst");
    tick();

    // Read/write and toggle.
    bus_write(3'd0, 8'h3C);
    check("pin_out_3c", pin_out, 8'h3C);
    bus_write(3'd7, 8'h0F);
    check("pin_out_toggle", pin_out, 8'h33);
    bus_read(3'd0, 8'h33, "rd_data_33");
    tick();
    check("do_idle_0", DO, 8'h00);
    bus_read(3'd7, 8'h00, "rd_toggle");
    tick();
    check("do_idle_7", DO, 8'h00);
    bus_write(3'd1, 8'h5A);
    check("pin_oe_5a", pin_oe, 8'h5A);
    bus_read(3'd1, 8'h5A, "rd_dir_5a");

    // Rising edge on bit 0 reaches status and irq on the third edge.
    bus_write(3'd4, 8'h01);
    bus_write(3'd3, 8'h01);
    pin_in[0] = 1'b1;
    tick();
    check("rise_e1_irq", irq, 1'b0);
    tick();
    check("rise_e2_irq", irq, 1'b0);
    tick();
    check("rise_e3_irq", irq, 1'b1);
    bus_read(3'd6, 8'h01, "rd_status_rise");
    bus_read(3'd2, 8'h01, "rd_pin_in");
    bus_write(3'd6, 8'h01);
    check("w1c_irq", irq, 1'b0);
    pin_in[0] = 1'b0;
    ticks(5);
    bus_read(3'd6, 8'h00, "rd_status_nofall");
    check("nofall_irq", irq, 1'b0);

    // Both-edge mode on bit 7 with irq masked.
    bus_write(3'd4, 8'h80);
    bus_write(3'd5, 8'h80);
    bus_write(3'd3, 8'h00);
    pin_in[7] = 1'b1;
    ticks(3);
    check("both_rise_irq_masked", irq, 1'b0);
    bus_read(3'd6, 8'h80, "rd_status_b7_rise");
    bus_write(3'd6, 8'h80);
    tick();
    pin_in[7] = 1'b0;
    ticks(4);
    bus_read(3'd6, 8'h80, "rd_status_b7_fall");
    check("both_fall_irq_masked", irq, 1'b0);
    bus_write(3'd3, 8'h80);
    check("irq_en_raises", irq, 1'b1);
    bus_write(3'd6, 8'h80);
    check("irq_b7_cleared", irq, 1'b0);

    // W1C arriving in the same cycle as a new rising event: set wins.
    bus_write(3'd4, 8'h01);
    bus_write(3'd5, 8'h00);
    bus_write(3'd3, 8'h01);
    pin_in[0] = 1'b1;
    ticks(2);
    bus_write(3'd6, 8'h01);
    check("collide_irq", irq, 1'b1);
    bus_read(3'd6, 8'h01, "rd_status_collide");
    bus_write(3'd6, 8'h01);
    check("collide_later_irq", irq, 1'b0);
    bus_read(3'd6, 8'h00, "rd_status_cleared");

    // WIDTH=3 instance: upper register bits ignored and read as 0.
    bus_write(3'd1, 8'hFF, 1);
    check("w3_pin_oe", pin_oe3, 3'h7);
    bus_read(3'd1, 8'h07, "w3_rd_dir", 1);
    bus_write(3'd4, 8'hFF, 1);
    bus_read(3'd4, 8'h07, "w3_rd_rise", 1);
    bus_write(3'd3, 8'hFF, 1);
    pin_in3 = 3'b111;
    ticks(3);
    check("w3_irq", irq3, 1'b1);
    bus_read(3'd2, 8'h07, "w3_rd_pin_in", 1);
    bus_read(3'd6, 8'h07, "w3_rd_status", 1);
    bus_write(3'd0, 8'hFF, 1);
    bus_read(3'd0, 8'h07, "w3_rd_data", 1);

    ticks(2);
    check("sb_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_port.md
# gpio_port

Parametrised memory-mapped GPIO peripheral for the 6502 system bus, replacing the fixed write-only LED register in the system top. It provides up to 8 bidirectional pins with per-pin direction, an output toggle register, synchronised input readback, and per-pin rising/falling edge detection with a maskable, level-sensitive IRQ output to the CPU. It attaches to the shared bus like the ROM, RAM and UART blocks: an 8-bit address slice, separate DI/DO buses, CS and WE.

## Interface
- WIDTH, 8: number of pins, 1..8; register bits at or above WIDTH are ignored on write and read 0
- RESET_OUT, 8'h00: DATA_OUT value at reset, truncated to WIDTH
- SYNC_STAGES, 2: input synchroniser depth, 2..4
- clk  in  1  system clock; every register updates on its rising edge
- reset  in  1  asynchronous, active-high reset
- AB  in  3  register select (bus address bits [2:0])
- DI  in  8  write data from the CPU
- DO  out  8  registered read data; 8'h00 when not returning a read
- CS  in  1  chip select, decoded by the system top
- WE  in  1  write enable, active high
- pin_in  in  WIDTH  raw, asynchronous pad inputs
- pin_out  out  WIDTH  DATA_OUT register
- pin_oe  out  WIDTH  DIR register; 1 = drive the pin
- irq  out  1  |(IRQ_STATUS & IRQ_EN)

## Operation
- Register map (AB):
  - 0 DATA_OUT, R/W
  - 1 DIR, R/W
  - 2 PIN_IN, R; synchroniser output
  - 3 IRQ_EN, R/W
  - 4 EDGE_RISE, R/W
  - 5 EDGE_FALL, R/W
  - 6 IRQ_STATUS, R; write 1 to clear
  - 7 TOGGLE, W; DATA_OUT ^= DI; reads 8'h00
- Write: at a clk edge with CS=1 and WE=1, the selected register updates from DI[WIDTH-1:0].
- Read: at a clk edge with CS=1 and WE=0, DO <= selected register, zero-extended. At every other edge DO <= 8'h00, so the top can OR all slave DO buses together.
- Synchroniser: pin_in passes through SYNC_STAGES flops (s). A prev flop holds the last s value.
- Edge event for bit i: rise = s & ~prev & EDGE_RISE; fall = ~s & prev & EDGE_FALL.
  - A bit can be in both-edge mode when both enables are set.
- IRQ_STATUS[i] sets on any event, regardless of IRQ_EN. IRQ_EN masks only irq.
- Edge detection runs on every pin, including pins driven as outputs (loopback through the pad).
- Simultaneous events:
  - A set and a W1C on the same bit in the same cycle: set wins.
  - A write to DATA_OUT takes precedence over TOGGLE; they cannot coincide because each cycle has one address.
- Reset, asserted asynchronously at any time including mid-access:
  - DATA_OUT=RESET_OUT
  - DIR, IRQ_EN, EDGE_RISE, EDGE_FALL, IRQ_STATUS, synchroniser and prev flops = 0
  - DO=8'h00, pin_oe=0, irq=0
- A pin held high through reset release gives no status, because EDGE_RISE=0 until software writes it.

## Timing
- Write to DATA_OUT/DIR: pin_out/pin_oe change at the same edge that samples the write.
- Read latency: data appears on DO one edge after CS&~WE is sampled, and is held for one cycle.
- Pin-to-PIN_IN latency: SYNC_STAGES edges.
- Pin-to-IRQ_STATUS latency: SYNC_STAGES+1 edges. irq rises combinationally after that edge when the bit is enabled.
- W1C: the status bit and irq drop at the write edge. An event in that same cycle keeps the bit set.
- Pulses shorter than one clk period may be missed; this is not guaranteed.

## Test plan
- Reset values: with RESET_OUT=8'hA5, assert reset mid-write of DIR=8'hFF. Required: pin_out=8'hA5, pin_oe=0, irq=0, DO=0; reading AB=1 after release returns 8'h00.
- R/W and toggle: write DATA_OUT=8'h3C, then TOGGLE=8'h0F. Required: pin_out=8'h33, DATA_OUT reads 8'h33, TOGGLE reads 8'h00, DO=0 in the idle cycle after each read.
- Rising edge IRQ: set EDGE_RISE=8'h01 and IRQ_EN=8'h01, then pin_in[0] goes 0->1. Required: STATUS=8'h01 and irq=1 exactly 3 edges later with SYNC_STAGES=2; no event on the 1->0 transition.
- Both-edge and mask: set EDGE_RISE=EDGE_FALL=8'h80 and IRQ_EN=0, then pulse pin_in[7] high for 5 cycles. Required: STATUS[7]=1 and irq=0; setting IRQ_EN=8'h80 raises irq on the write edge.
- W1C collision: write STATUS=8'h01 in the same cycle a new rising event on bit 0 reaches status. Required: STATUS[0] stays 1 and irq stays 1; a later W1C clears it.
- WIDTH=3: write DIR=8'hFF. Required: reads 8'h07; events on bits 3..7 are impossible and PIN_IN[7:3] reads 0.
